branch_predictor: RTL and testbench
===================================

# branch_predictor

Gshare direction predictor for the RV32I pipeline. Fetch queries it each cycle for a predicted `br_en`; when the branch reaches the comparator in execute, the actual `br_en` is written back to train the predictor and repair speculative history. It also produces a registered mispredict pulse and saturating branch/mispredict statistics counters.

## Interface
- `INDEX_BITS`, default 5: log2 of pattern history table (PHT) entries; also the global history register (GHR) width.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pred_valid`  in  1  fetch holds a conditional branch this cycle.
- `pred_pc`  in  32  PC of the fetched branch.
- `pred_taken`  out  1  predicted direction for `pred_pc`; combinational.
- `pred_ghr`  out  INDEX_BITS  GHR snapshot used for this prediction; combinational. The pipeline carries it to execute.
- `res_valid`  in  1  a conditional branch resolves in execute this cycle.
- `res_pc`  in  32  PC of the resolving branch.
- `res_br_en`  in  1  actual outcome from the comparator.
- `res_pred_taken`  in  1  direction that was predicted for this branch.
- `res_ghr`  in  INDEX_BITS  GHR snapshot carried with this branch.
- `mispredict`  out  1  registered; one-cycle pulse when a resolved branch was mispredicted.
- `stat_branches`  out  32  count of resolved branches; saturating.
- `stat_mispredicts`  out  32  count of mispredicted branches; saturating.

## Operation
- **PHT:** 2^INDEX_BITS entries of 2-bit saturating counters.
  - Encoding: 00 strong not-taken, 01 weak NT, 10 weak T, 11 strong T.
  - Prediction is counter bit 1.
- **Prediction index:** `pred_pc[INDEX_BITS+1:2] ^ ghr`.
  - `pred_taken` = PHT[index][1] whenever `pred_valid` = 1.
  - `pred_taken` = 0 when `pred_valid` = 0.
  - `pred_ghr` = current `ghr` at all times.
- **Training index:** `res_pc[INDEX_BITS+1:2] ^ res_ghr`.
  - On `res_valid`, the counter increments if `res_br_en` = 1 (saturates at 11) and decrements otherwise (saturates at 00).
- **Speculative GHR update:**
  - If `pred_valid` and no mispredict repair this cycle: `ghr <= {ghr[INDEX_BITS-2:0], pred_taken}`.
- **Repair:**
  - Mispredict condition: `res_valid` and `res_br_en != res_pred_taken`.
  - On mispredict: `ghr <= {res_ghr[INDEX_BITS-2:0], res_br_en}`.
  - Repair has priority over a same-cycle speculative update; the fetch-side branch is being flushed.
- **mispredict output:** next cycle, `mispredict <= res_valid & (res_br_en != res_pred_taken)`.
- **Statistics:**
  - `stat_branches` increments on each `res_valid`.
  - `stat_mispredicts` increments on each mispredict.
  - Both hold at 0xFFFF_FFFF once reached; they never wrap.
- **Unknown inputs:** `res_valid` with X on `res_br_en` is a fatal simulation error. Use an assertion, consistent with other datapath units.

## Timing
- **Reset (`rst` = 0, asynchronous):**
  - Every PHT entry = 01.
  - `ghr` = 0, `mispredict` = 0, both stat counters = 0.
  - Hence `pred_taken` = 0 and `pred_ghr` = 0 during and immediately after reset.
- **Reset mid-operation:** all state clears immediately, with no dependence on a clock edge. Outputs are valid reset values within the same cycle.
- **Prediction latency:** 0 cycles; combinational from `pred_pc` and state.
- **Training latency:** 1 cycle.
  - A PHT write at edge N is visible to a prediction in cycle N+1.
  - A same-cycle read and write of the same index returns the old counter; there is no bypass.
- **mispredict:** asserted exactly in the cycle after the resolving cycle, for one cycle. Back-to-back mispredicts produce back-to-back pulses.
- **Simultaneous events:**
  - `pred_valid` and `res_valid` in one cycle: both the PHT training and the GHR action occur on that edge.
  - GHR action: repair if mispredicted, otherwise speculative shift.
- **Wrap-around:**
  - GHR shift discards the MSB.
  - PC bits above INDEX_BITS+1 are ignored, so aliasing is permitted.

## Test plan
- **Reset:** deassert `rst` and query `pred_pc` = 0x0000_0040 -> `pred_taken` = 0, `pred_ghr` = 0, `mispredict` = 0, stats = 0.
- **Training saturation:**
  - Stimulus: resolve pc 0x40, `res_ghr` = 0, taken, three times, with `res_pred_taken` = 0, 1, 1.
  - Required: counter 01→10→11→11. `pred_taken` = 1 for pc 0x40 with ghr = 0 from the cycle after the first write. `mispredict` pulses once. `stat_branches` = 3, `stat_mispredicts` = 1.
- **Speculative GHR:**
  - Stimulus: after reset, 5 predictions with `pred_valid` = 1 at pc 0x100, all predicting 0.
  - Required: ghr stays 0. Then train index 0 to 10 and predict at pc 0x0 -> taken; next `pred_ghr` = 00001.
- **Repair priority:**
  - Stimulus: ghr = 00011. In one cycle, `pred_valid` = 1 and a mispredicted resolve with `res_ghr` = 00101, `res_br_en` = 1.
  - Required: ghr = 01011 next cycle, not the speculative value.
- **Reset mid-stream:** assert `rst` asynchronously between clock edges after training -> PHT returns to 01 everywhere, ghr = 0, stats = 0 before the next edge.
- **Counter saturation:** force `stat_mispredicts` to 0xFFFF_FFFE, then apply 3 mispredicts -> holds at 0xFFFF_FFFF.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor: gshare direction predictor with history repair and saturating statistics
module branch_predictor #(
  parameter int INDEX_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_valid,
  input  logic [31:0]           pred_pc,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_ghr,
  input  logic                  res_valid,
  input  logic [31:0]           res_pc,
  input  logic                  res_br_en,
  input  logic                  res_pred_taken,
  input  logic [INDEX_BITS-1:0] res_ghr,
  output logic                  mispredict,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
);
  localparam int N = 1 << INDEX_BITS;
  logic [1:0]            pht [N];
  logic [INDEX_BITS-1:0] ghr, pidx, ridx;
  logic [1:0]            cnt, cnt_nxt;
  logic                  mis;
  // Index hashing, prediction lookup, and saturating counter step for training
  always_comb begin
    pidx       = pred_pc[INDEX_BITS+1:2] ^ ghr;
    ridx       = res_pc[INDEX_BITS+1:2] ^ res_ghr;
    pred_taken = pred_valid & pht[pidx][1];
    pred_ghr   = ghr;
    mis        = res_valid & (res_br_en != res_pred_taken);
    cnt        = pht[ridx];
    cnt_nxt    = res_br_en ? (&cnt ? cnt : cnt + 2'd1) : (|cnt ? cnt - 2'd1 : cnt);
  end
  // PHT trains on resolve; a same-cycle lookup sees the old counter
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < N; i++) pht[i] <= 2'b01;
    else if (res_valid)
      pht[ridx] <= cnt_nxt;
  // History repair wins over speculative shift since the fetched branch is flushed
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      ghr <= '0;
    else if (mis)
      ghr <= {res_ghr[INDEX_BITS-2:0], res_br_en};
    else if (pred_valid)
      ghr <= {ghr[INDEX_BITS-2:0], pred_taken};
  // Registered mispredict pulse and saturating statistics
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mispredict       <= 1'b0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      mispredict <= mis;
      if (res_valid && !(&stat_branches)) stat_branches <= stat_branches + 32'd1;
      if (mis && !(&stat_mispredicts)) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  // A resolving branch must carry a known outcome
  assert property (@(posedge clk) disable iff (!rst) res_valid |-> !$isunknown(res_br_en))
    else $fatal(1, "branch_predictor: res_br_en unknown on res_valid");
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: table vectors, directed corner sequences and randomized model comparison
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_taken;
  logic [4:0]  pred_ghr;
  logic        res_valid = 1'b0;
  logic [31:0] res_pc = '0;
  logic        res_br_en = 1'b0;
  logic        res_pred_taken = 1'b0;
  logic [4:0]  res_ghr = '0;
  logic        mispredict;
  logic [31:0] stat_branches, stat_mispredicts;

  branch_predictor #(.INDEX_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .res_valid(res_valid), .res_pc(res_pc), .res_br_en(res_br_en),
    .res_pred_taken(res_pred_taken), .res_ghr(res_ghr),
    .mispredict(mispredict), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain integers, counters clamped to 0..3, history as a number mod 32
  localparam longint SAT = 64'hFFFF_FFFF;
  int     pht_m [32];
  int     ghr_m;
  longint sb_m, sm_m;
  bit     mis_m;
  bit     s_tk;

  function automatic void m_reset();
    foreach (pht_m[i]) pht_m[i] = 1;
    ghr_m = 0; sb_m = 0; sm_m = 0; mis_m = 0;
  endfunction

  function automatic int idx_of(input bit [31:0] pc, input int h);
    return int'((pc >> 2) % 32) ^ h;
  endfunction

  task automatic step(input bit pv, input bit [31:0] ppc, input bit rv, input bit [31:0] rpc,
                      input bit rbe, input bit rpt, input bit [4:0] rg, input bit cm);
    bit m_tk, m_mis;
    int ri;
    @(negedge clk);
    pred_valid = pv; pred_pc = ppc; res_valid = rv; res_pc = rpc;
    res_br_en = rbe; res_pred_taken = rpt; res_ghr = rg;
    #1;
    s_tk = pred_taken;
    m_tk = pv && (pht_m[idx_of(ppc, ghr_m)] >= 2);
    if (cm) begin
      chk("rnd_pred_taken", pred_taken, m_tk);
      chk("rnd_pred_ghr", pred_ghr, ghr_m);
    end
    @(posedge clk);
    m_mis = rv && (rbe != rpt);
    if (rv) begin
      ri = idx_of(rpc, int'(rg));
      pht_m[ri] = rbe ? ((pht_m[ri] + 1 > 3) ? 3 : pht_m[ri] + 1) : ((pht_m[ri] - 1 < 0) ? 0 : pht_m[ri] - 1);
    end
    ghr_m = m_mis ? (int'(rg) * 2 + int'(rbe)) % 32 : pv ? (ghr_m * 2 + int'(m_tk)) % 32 : ghr_m;
    if (rv && sb_m < SAT) sb_m++;
    if (m_mis && sm_m < SAT) sm_m++;
    mis_m = m_mis;
    #1;
    if (cm) begin
      chk("rnd_mispredict", mispredict, mis_m);
      chk("rnd_ghr_after", pred_ghr, ghr_m);
      chk("rnd_stat_branches", stat_branches, sb_m);
      chk("rnd_stat_mispredicts", stat_mispredicts, sm_m);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; pred_valid = 0; res_valid = 0;
    #2;
    rst = 1'b1;
    m_reset();
  endtask

  typedef struct {
    bit        pv;
    bit [31:0] ppc;
    bit        rv;
    bit [31:0] rpc;
    bit        rbe, rpt;
    bit [4:0]  rg;
    bit        e_tk;
    bit [4:0]  e_ghr;
    bit        e_mis;
    int        e_sb, e_sm;
  } vec_t;
  vec_t tbl [7];

  initial begin
    // pv ppc  rv rpc  rbe rpt rg | taken ghr_after mis sb sm
    tbl[0] = '{1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 0, 0};
    tbl[1] = '{1'b0, 32'h0,   1'b1, 32'h40,  1'b1, 1'b0, 5'd0, 1'b0, 5'd1,  1'b1, 1, 1};
    tbl[2] = '{1'b1, 32'h44,  1'b1, 32'h40,  1'b1, 1'b1, 5'd0, 1'b1, 5'd3,  1'b0, 2, 1};
    tbl[3] = '{1'b0, 32'h0,   1'b1, 32'h40,  1'b1, 1'b1, 5'd0, 1'b0, 5'd3,  1'b0, 3, 1};
    tbl[4] = '{1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 5'd5, 1'b0, 5'd11, 1'b1, 4, 2};
    tbl[5] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b0, 4, 2};
    tbl[6] = '{1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 1'b0, 5'd0, 1'b0, 5'd22, 1'b0, 4, 2};

    // Reset state, during and right after reset
    pred_valid = 1; pred_pc = 32'h40;
    #3;
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_pred_ghr", pred_ghr, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_stat_branches", stat_branches, 0);
    chk("rst_stat_mispredicts", stat_mispredicts, 0);
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    #1;
    chk("post_rst_pred_taken", pred_taken, 0);
    chk("post_rst_pred_ghr", pred_ghr, 0);

    // Training saturation and repair priority table
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].pv, tbl[i].ppc, tbl[i].rv, tbl[i].rpc, tbl[i].rbe, tbl[i].rpt, tbl[i].rg, 1'b0);
      chk($sformatf("tbl%0d_taken", i), s_tk, tbl[i].e_tk);
      chk($sformatf("tbl%0d_ghr", i), pred_ghr, tbl[i].e_ghr);
      chk($sformatf("tbl%0d_mispredict", i), mispredict, tbl[i].e_mis);
      chk($sformatf("tbl%0d_stat_branches", i), stat_branches, tbl[i].e_sb);
      chk($sformatf("tbl%0d_stat_mispredicts", i), stat_mispredicts, tbl[i].e_sm);
    end

    // Speculative history: not-taken predictions keep ghr at zero
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h100, 0, 0, 0, 0, 0, 1'b0);
      chk("spec_ghr_zero", pred_ghr, 0);
    end
    step(0, 0, 1, 32'h0, 1, 1, 5'd0, 1'b0);
    step(1, 32'h0, 0, 0, 0, 0, 0, 1'b0);
    chk("spec_taken_idx0", s_tk, 1);
    chk("spec_ghr_shift1", pred_ghr, 1);

    // Asynchronous reset between edges clears PHT, ghr and stats before the next edge
    #1;
    pred_valid = 1; pred_pc = 32'h4; res_valid = 0;
    #1;
    chk("mid_pre_taken", pred_taken, 1);
    rst = 1'b0;
    pred_pc = 32'h0;
    #1;
    chk("mid_rst_taken", pred_taken, 0);
    chk("mid_rst_ghr", pred_ghr, 0);
    chk("mid_rst_stat_branches", stat_branches, 0);
    chk("mid_rst_mispredict", mispredict, 0);
    @(negedge clk);
    rst = 1'b1;
    m_reset();

    // Mispredict counter holds at all-ones
    force dut.stat_mispredicts = 32'hFFFF_FFFE;
    #1;
    release dut.stat_mispredicts;
    sm_m = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 32'h40, 1, 0, 5'd0, 1'b1);
      chk("sat_stat_mispredicts", stat_mispredicts, 32'hFFFF_FFFF);
    end

    // Randomized traffic against the reference model, with aliasing PCs
    for (int i = 0; i < 400; i++) begin
      bit [31:0] ppc, rpc;
      bit [4:0]  rg;
      ppc = {$urandom_range(0, 255), 2'b00};
      rpc = {$urandom_range(0, 255), 2'b00};
      rg  = ($urandom_range(0, 1) == 1) ? 5'(ghr_m) : 5'($urandom_range(0, 31));
      step($urandom_range(0, 1) == 1, ppc, $urandom_range(0, 2) != 0, rpc,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rg, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
